// File: rtl/spi_ram_arbiter.sv
// SPI frame decoder and round-robin RAM sequencer shared between the SPI
// command path and a local host port.
module spi_ram_arbiter #(
    parameter int AUTO_INC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] rx_data,
    input  logic       rx_valid,
    input  logic       ss_n,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       host_gnt,
    output logic [7:0] host_rdata,
    output logic       host_rvalid,
    output logic       ram_en,
    output logic       ram_we,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    output logic       drop_err
);
    typedef enum logic [1:0] {IDLE, ACC, RCAP} state_t;

    localparam logic       SRC_SPI  = 1'b0;
    localparam logic       SRC_HOST = 1'b1;
    localparam logic [7:0] INC      = 8'(AUTO_INC);

    state_t     state;
    logic       rx_prev;
    logic       spi_pend;
    logic       pend_rd;
    logic [7:0] pend_data;
    logic [7:0] wr_addr;
    logic [7:0] rd_addr;
    logic       last_gnt;
    logic       cur_host;
    logic       cur_we;

    logic rx_rise;
    logic grant_spi;
    logic grant_host;

    assign rx_rise    = rx_valid & ~rx_prev;
    // On a tie the source that was not served last wins.
    assign grant_spi  = spi_pend & (~host_req | (last_gnt == SRC_HOST));
    assign grant_host = host_req & (~spi_pend | (last_gnt == SRC_SPI));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rx_prev     <= 1'b0;
            spi_pend    <= 1'b0;
            pend_rd     <= 1'b0;
            pend_data   <= 8'h00;
            wr_addr     <= 8'h00;
            rd_addr     <= 8'h00;
            last_gnt    <= SRC_HOST;
            cur_host    <= 1'b0;
            cur_we      <= 1'b0;
            tx_data     <= 8'h00;
            tx_valid    <= 1'b0;
            host_gnt    <= 1'b0;
            host_rdata  <= 8'h00;
            host_rvalid <= 1'b0;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= 8'h00;
            ram_wdata   <= 8'h00;
            drop_err    <= 1'b0;
        end else begin
            rx_prev     <= rx_valid;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            host_gnt    <= 1'b0;
            host_rvalid <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_spi) begin
                        ram_en   <= 1'b1;
                        ram_we   <= ~pend_rd;
                        ram_addr <= pend_rd ? rd_addr : wr_addr;
                        if (!pend_rd)
                            ram_wdata <= pend_data;
                        spi_pend <= 1'b0;
                        last_gnt <= SRC_SPI;
                        cur_host <= 1'b0;
                        cur_we   <= ~pend_rd;
                        state    <= ACC;
                    end else if (grant_host) begin
                        ram_en   <= 1'b1;
                        ram_we   <= host_we;
                        ram_addr <= host_addr;
                        if (host_we)
                            ram_wdata <= host_wdata;
                        host_gnt <= 1'b1;
                        last_gnt <= SRC_HOST;
                        cur_host <= 1'b1;
                        cur_we   <= host_we;
                        state    <= ACC;
                    end
                end
                ACC: begin
                    if (!cur_host) begin
                        if (cur_we)
                            wr_addr <= wr_addr + INC;
                        else
                            rd_addr <= rd_addr + INC;
                    end
                    state <= cur_we ? IDLE : RCAP;
                end
                RCAP: begin
                    if (cur_host) begin
                        host_rdata  <= ram_rdata;
                        host_rvalid <= 1'b1;
                    end else begin
                        tx_data  <= ram_rdata;
                        tx_valid <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Placed after the FSM so an explicit address load beats a post-increment.
            if (rx_rise) begin
                if (spi_pend) begin
                    drop_err <= 1'b1;
                end else begin
                    case (rx_data[9:8])
                        2'b00: wr_addr <= rx_data[7:0];
                        2'b01: begin
                            spi_pend  <= 1'b1;
                            pend_rd   <= 1'b0;
                            pend_data <= rx_data[7:0];
                        end
                        2'b10: rd_addr <= rx_data[7:0];
                        default: begin
                            spi_pend <= 1'b1;
                            pend_rd  <= 1'b1;
                        end
                    endcase
                end
            end

            if (rx_rise || ss_n)
                tx_valid <= 1'b0;
        end
    end
endmodule
